// File: rtl/mdim_pack_pkg.sv
// mdim_pack_pkg: shared types and helpers for the mdim_pack_gather lane packer.
//   state_t   : FILL while lanes are being collected, FULL while a frame is offered
//   lane_mask : keep mask for zero-padding; bit i is set for lanes 0..idx
package mdim_pack_pkg;

   typedef enum logic {FILL, FULL} state_t;

   // Upper bound on lanes the mask helper can describe; callers cast down to NCH.
   localparam int MAX_LANES = 64;

   function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned idx);
      logic [MAX_LANES-1:0] m;
      for (int unsigned i = 0; i < MAX_LANES; i++) m[i] = (i <= idx);
      return m;
   endfunction

endpackage

// File: rtl/mdim_pack_gather_lane_cnt.sv
// mdim_lane_cnt: lane index counter for the packer.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance index by one
//   clr      : return index to 0 (wins over inc)
//   idx      : current lane index, CW bits
//   term     : index sits on the last lane (N-1)
module mdim_lane_cnt #(
   parameter  int N  = 2,
   localparam int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] idx,
   output logic          term
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      idx <= '0;
      else if (clr) idx <= '0;
      else if (inc) idx <= idx + CW'(1);
   end

   assign term = (idx == CW'(N - 1));

endmodule

// File: rtl/mdim_pack_gather.sv
// mdim_pack_gather: serial-to-parallel lane packer.
// Collects up to NCH words of W bits into one frame (lane 0 in the LSBs) and
// offers it downstream; in_last closes a frame early with the upper lanes zeroed.
// Optional feature macro: MDIM_PACK_PARITY_EN adds out_parity (even parity per lane).
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : in_data valid          in_ready  : beat accepted this cycle
//   in_data    : lane word (W)          in_last   : close the frame with this beat
//   out_valid  : frame complete         out_ready : consumer takes the frame
//   out_data   : packed frame, lane i at [i*W +: W]
//   out_parity : (optional) bit i = ^lane i, 0 for padded lanes
//   out_count  : number of lanes filled in the offered frame
module mdim_pack_gather
   import mdim_pack_pkg::*;
#(
   parameter  int W   = 4,
   parameter  int NCH = 2,
   localparam int CW  = $clog2(NCH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NCH*W-1:0]   out_data,
`ifdef MDIM_PACK_PARITY_EN
   output logic [NCH-1:0]     out_parity,
`endif
   output logic [CW:0]        out_count
);

   state_t                  state, state_nxt;
   logic [CW-1:0]           idx;
   logic                    term;
   logic                    acc;     // beat accepted
   logic                    cls;     // accepted beat closes the frame
   logic [NCH-1:0]          keep;
   logic [NCH-1:0][W-1:0]   frame_q, frame_nxt;
   logic [CW:0]             cnt_q;

   mdim_lane_cnt #(.N(NCH)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (acc & ~cls),
      .clr  (cls),
      .idx  (idx),
      .term (term)
   );

   // In FULL the index is always 0, so a same-cycle accept lands in lane 0 of
   // the next frame and can only close it through in_last.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b1;
      out_valid = 1'b0;
      acc       = 1'b0;
      cls       = 1'b0;
      case (state)
         FILL: begin
            acc = in_valid;
            cls = in_valid & (term | in_last);
            if (cls) state_nxt = FULL;
         end
         FULL: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            acc       = in_valid & out_ready;
            cls       = acc & (term | in_last);
            if (out_ready) state_nxt = cls ? FULL : FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   // Every accepted beat keeps lanes below idx, writes lane idx and clears the
   // lanes above, so a new frame never inherits words from the previous one.
   assign keep = NCH'(lane_mask(32'(idx)));

   always_comb begin
      frame_nxt = frame_q;
      if (acc) begin
         for (int i = 0; i < NCH; i++) begin
            if (CW'(i) == idx) frame_nxt[i] = in_data;
            else if (!keep[i]) frame_nxt[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (acc) frame_q <= frame_nxt;
         if (cls) cnt_q   <= {1'b0, idx} + {{CW{1'b0}}, 1'b1};
      end
   end

   assign out_data  = frame_q;
   assign out_count = cnt_q;

`ifdef MDIM_PACK_PARITY_EN
   logic [NCH-1:0] par_q, par_nxt;

   always_comb begin
      par_nxt = '0;
      for (int i = 0; i < NCH; i++) par_nxt[i] = ^frame_nxt[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      par_q <= '0;
      else if (acc) par_q <= par_nxt;
   end

   assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_mdim_pack_gather.sv
// tb_mdim_pack_gather: directed checks of mdim_pack_gather at NCH=2 and NCH=4
// (W=4), plus a random valid/ready scoreboard on the NCH=4 instance.
// Parity checks are compiled in when MDIM_PACK_PARITY_EN is defined.
module tb_mdim_pack_gather;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // NCH=2 instance
   logic       v2, l2, or2, ir2, ov2;
   logic [3:0] d2;
   logic [7:0] od2;
   logic [1:0] oc2;
   // NCH=4 instance
   logic        v4, l4, or4, ir4, ov4;
   logic [3:0]  d4;
   logic [15:0] od4;
   logic [2:0]  oc4;
`ifdef MDIM_PACK_PARITY_EN
   logic [1:0] par2;
   logic [3:0] par4;
`endif

   int vec  = 0;
   int miss = 0;

   mdim_pack_gather #(.W(4), .NCH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(d2), .in_last(l2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2),
`ifdef MDIM_PACK_PARITY_EN
      .out_parity(par2),
`endif
      .out_count(oc2));

   mdim_pack_gather #(.W(4), .NCH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_data(d4), .in_last(l4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4),
`ifdef MDIM_PACK_PARITY_EN
      .out_parity(par4),
`endif
      .out_count(oc4));

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      v2 = 0; l2 = 0; or2 = 0; d2 = '0;
      v4 = 0; l4 = 0; or4 = 0; d4 = '0;
      rst = 1'b1; #2;
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      v2 = 0; l2 = 0; or2 = 0; d2 = '0;
      v4 = 0; l4 = 0; or4 = 0; d4 = '0;
      rst = 1'b1; #1;
      vec++; if (ov2 !== 1'b0)  begin miss++; $display("FAIL reset_ovalid got %0b want 0", ov2); end
      vec++; if (oc2 !== 2'd0)  begin miss++; $display("FAIL reset_count got %0d want 0", oc2); end
      vec++; if (ir2 !== 1'b1)  begin miss++; $display("FAIL reset_iready got %0b want 1", ir2); end
      vec++; if (od2 !== 8'h00) begin miss++; $display("FAIL reset_data got %h want 00", od2); end
      vec++; if (ov4 !== 1'b0)  begin miss++; $display("FAIL reset_ovalid4 got %0b want 0", ov4); end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      do_reset();
      or2 = 1; v2 = 1; d2 = 4'h3; #1;
      vec++; if (ir2 !== 1'b1) begin miss++; $display("FAIL basic_iready got %0b want 1", ir2); end
      step();
      vec++; if (ov2 !== 1'b0) begin miss++; $display("FAIL basic_early_valid got %0b want 0", ov2); end
      d2 = 4'h5; step();
      vec++; if (ov2 !== 1'b1)  begin miss++; $display("FAIL basic_valid got %0b want 1", ov2); end
      vec++; if (od2 !== 8'h53) begin miss++; $display("FAIL basic_data got %h want 53", od2); end
      vec++; if (oc2 !== 2'd2)  begin miss++; $display("FAIL basic_count got %0d want 2", oc2); end
      v2 = 0; step();
      vec++; if (ov2 !== 1'b0) begin miss++; $display("FAIL basic_drop got %0b want 0", ov2); end
   endtask

   task automatic test_last();
      do_reset();
      or4 = 1; v4 = 1;
      for (int k = 0; k < 4; k++) begin d4 = 4'(12 + k); step(); end
      vec++; if (ov4 !== 1'b1)     begin miss++; $display("FAIL full4_valid got %0b want 1", ov4); end
      vec++; if (od4 !== 16'hFEDC) begin miss++; $display("FAIL full4_data got %h want FEDC", od4); end
      vec++; if (oc4 !== 3'd4)     begin miss++; $display("FAIL full4_count got %0d want 4", oc4); end
      d4 = 4'h1; step();
      vec++; if (ov4 !== 1'b0) begin miss++; $display("FAIL last_midvalid got %0b want 0", ov4); end
      d4 = 4'h2; step();
      d4 = 4'h3; l4 = 1; step();
      vec++; if (ov4 !== 1'b1)     begin miss++; $display("FAIL last_valid got %0b want 1", ov4); end
      vec++; if (od4 !== 16'h0321) begin miss++; $display("FAIL last_data got %h want 0321", od4); end
      vec++; if (oc4 !== 3'd3)     begin miss++; $display("FAIL last_count got %0d want 3", oc4); end
      l4 = 0;
      for (int k = 4; k < 7; k++) begin d4 = 4'(k); step(); end
      d4 = 4'h7; l4 = 1; step();
      vec++; if (od4 !== 16'h7654) begin miss++; $display("FAIL last_on_top_data got %h want 7654", od4); end
      vec++; if (oc4 !== 3'd4)     begin miss++; $display("FAIL last_on_top_count got %0d want 4", oc4); end
      v4 = 0; l4 = 0; step();
   endtask

   task automatic test_stall();
      do_reset();
      or2 = 0; v2 = 1; d2 = 4'h1; step();
      d2 = 4'h2; step();
      d2 = 4'h9;
      for (int k = 0; k < 5; k++) begin
         vec++; if (ir2 !== 1'b0)  begin miss++; $display("FAIL stall_iready cyc %0d got %0b want 0", k, ir2); end
         vec++; if (ov2 !== 1'b1)  begin miss++; $display("FAIL stall_valid cyc %0d got %0b want 1", k, ov2); end
         vec++; if (od2 !== 8'h21) begin miss++; $display("FAIL stall_data cyc %0d got %h want 21", k, od2); end
         step();
      end
      or2 = 1; #1;
      vec++; if (ir2 !== 1'b1) begin miss++; $display("FAIL stall_release_iready got %0b want 1", ir2); end
      step();
      vec++; if (ov2 !== 1'b0) begin miss++; $display("FAIL stall_refill_valid got %0b want 0", ov2); end
      d2 = 4'hA; step();
      vec++; if (ov2 !== 1'b1)  begin miss++; $display("FAIL stall_next_valid got %0b want 1", ov2); end
      vec++; if (od2 !== 8'hA9) begin miss++; $display("FAIL stall_next_data got %h want A9", od2); end
      d2 = 4'h1; step();
      d2 = 4'h2; step();
      vec++; if (od2 !== 8'h21) begin miss++; $display("FAIL stall_third_data got %h want 21", od2); end
      v2 = 0; step();
   endtask

   task automatic test_back_to_back();
      int frames = 0;
      do_reset();
      or2 = 1; v2 = 1;
      for (int k = 1; k <= 8; k++) begin
         d2 = 4'(k); step();
         if (ov2 === 1'b1) frames++;
         if (k % 2 == 0) begin
            vec++; if (od2 !== {4'(k), 4'(k - 1)}) begin miss++; $display("FAIL b2b_data beat %0d got %h want %h", k, od2, {4'(k), 4'(k - 1)}); end
            vec++; if (ov2 !== 1'b1) begin miss++; $display("FAIL b2b_valid beat %0d got %0b want 1", k, ov2); end
         end else begin
            vec++; if (ov2 !== 1'b0) begin miss++; $display("FAIL b2b_gap beat %0d got %0b want 0", k, ov2); end
         end
      end
      vec++; if (frames != 4) begin miss++; $display("FAIL b2b_frames got %0d want 4", frames); end
      d2 = 4'h7; l2 = 1; step();
      vec++; if (ov2 !== 1'b1)  begin miss++; $display("FAIL xfer_last_valid got %0b want 1", ov2); end
      vec++; if (od2 !== 8'h07) begin miss++; $display("FAIL xfer_last_data got %h want 07", od2); end
      vec++; if (oc2 !== 2'd1)  begin miss++; $display("FAIL xfer_last_count got %0d want 1", oc2); end
      v2 = 0; l2 = 0; step();
      vec++; if (ov2 !== 1'b0) begin miss++; $display("FAIL xfer_last_drop got %0b want 0", ov2); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      or2 = 1; v2 = 1; d2 = 4'hB; step();
      v2 = 0; #1;
      rst = 1'b1; #1;
      vec++; if (ov2 !== 1'b0) begin miss++; $display("FAIL midrst_valid got %0b want 0", ov2); end
      vec++; if (oc2 !== 2'd0) begin miss++; $display("FAIL midrst_count got %0d want 0", oc2); end
      #1; rst = 1'b0;
      step();
      v2 = 1; d2 = 4'hC; step();
      vec++; if (ov2 !== 1'b0) begin miss++; $display("FAIL midrst_first_valid got %0b want 0", ov2); end
      d2 = 4'hD; step();
      vec++; if (ov2 !== 1'b1)  begin miss++; $display("FAIL midrst_frame_valid got %0b want 1", ov2); end
      vec++; if (od2 !== 8'hDC) begin miss++; $display("FAIL midrst_frame_data got %h want DC", od2); end
      vec++; if (oc2 !== 2'd2)  begin miss++; $display("FAIL midrst_frame_count got %0d want 2", oc2); end
      v2 = 0; step();
   endtask

`ifdef MDIM_PACK_PARITY_EN
   task automatic test_parity();
      do_reset();
      vec++; if (par2 !== 2'b00) begin miss++; $display("FAIL parity_reset got %b want 00", par2); end
      or2 = 1; v2 = 1; d2 = 4'h1; step();
      d2 = 4'h7; step();
      vec++; if (par2 !== 2'b11) begin miss++; $display("FAIL parity_71 got %b want 11", par2); end
      d2 = 4'h0; step();
      d2 = 4'h3; step();
      vec++; if (par2 !== 2'b00) begin miss++; $display("FAIL parity_30 got %b want 00", par2); end
      d2 = 4'h7; l2 = 1; step();
      vec++; if (par2 !== 2'b01) begin miss++; $display("FAIL parity_pad got %b want 01", par2); end
      v2 = 0; l2 = 0; step();
   endtask
`endif

   task automatic test_random();
      logic [15:0] q_data[$];
      logic [2:0]  q_cnt[$];
      logic [15:0] mf = '0;
      int midx = 0, beats = 0, cyc = 0;
      do_reset();
      while (beats < 10000 && cyc < 60000) begin
         v4  = ($urandom_range(0, 3) != 0);
         d4  = 4'($urandom);
         l4  = ($urandom_range(0, 7) == 0);
         or4 = ($urandom_range(0, 3) != 0);
         #1;
         if (ov4 === 1'b1 && or4) begin
            vec++;
            if (q_data.size() == 0) begin
               miss++; $display("FAIL rnd_dup got frame %h want none", od4);
            end else begin
               if (od4 !== q_data[0] || oc4 !== q_cnt[0]) begin
                  miss++; $display("FAIL rnd_frame got %h/%0d want %h/%0d", od4, oc4, q_data[0], q_cnt[0]);
               end
               void'(q_data.pop_front()); void'(q_cnt.pop_front());
            end
         end
         if (v4 && ir4 === 1'b1) begin
            mf[midx*4 +: 4] = d4;
            beats++;
            if (midx == 3 || l4) begin
               q_data.push_back(mf); q_cnt.push_back(3'(midx + 1));
               mf = '0; midx = 0;
            end else midx++;
         end
         step();
         cyc++;
      end
      vec++; if (beats != 10000) begin miss++; $display("FAIL rnd_timeout got %0d beats want 10000", beats); end
      v4 = 0; or4 = 1;
      for (int k = 0; k < 8 && q_data.size() != 0; k++) begin
         #1;
         if (ov4 === 1'b1) begin
            vec++;
            if (od4 !== q_data[0] || oc4 !== q_cnt[0]) begin
               miss++; $display("FAIL rnd_drain got %h/%0d want %h/%0d", od4, oc4, q_data[0], q_cnt[0]);
            end
            void'(q_data.pop_front()); void'(q_cnt.pop_front());
         end
         step();
      end
      vec++; if (q_data.size() != 0) begin miss++; $display("FAIL rnd_loss got %0d frames pending want 0", q_data.size()); end
   endtask

   initial begin
      rst = 1'b1;
      v2 = 0; l2 = 0; or2 = 0; d2 = '0;
      v4 = 0; l4 = 0; or4 = 0; d4 = '0;
      test_reset();
      test_basic();
      test_last();
      test_stall();
      test_back_to_back();
      test_reset_mid();
`ifdef MDIM_PACK_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
